sw_allocator: RTL and testbench
===============================

SW_ALLOCATOR -- requirements
Module: sw_allocator

Interface
REQ-001 SHALL have parameter NUM_INPORTS, default 3, number of input buffers (requesters).
REQ-002 SHALL have parameter NUM_OUTPORTS, default 2, number of output ports.
REQ-003 SHALL have parameter NUM_VCS, default 2, virtual channels per output.
REQ-004 SHALL have parameter BUFFER_SIZE, default 8, downstream buffer depth per VC (initial credits).
REQ-005 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-006 SHALL have port n_rst, input, 1, reset; synchronous, active-low.
REQ-007 SHALL have port req, input, [NUM_INPORTS], input i holds a head-of-buffer flit.
REQ-008 SHALL have port req_outport, input, [NUM_INPORTS][$clog2(NUM_OUTPORTS)], routed output for input i.
REQ-009 SHALL have port req_vc, input, [NUM_INPORTS][$clog2(NUM_VCS)], VC of input i's flit.
REQ-010 SHALL have port req_tail, input, [NUM_INPORTS], input i's flit is the last flit of its packet.
REQ-011 SHALL have port credit_return, input, [NUM_OUTPORTS][NUM_VCS], downstream freed one slot.
REQ-012 SHALL have port grant, output, [NUM_INPORTS], input i's flit moves this cycle; input pops it.
REQ-013 SHALL have port xbar_sel, output, [NUM_OUTPORTS][$clog2(NUM_INPORTS)], crossbar source per output.
REQ-014 SHALL have port xbar_valid, output, [NUM_OUTPORTS], output carries a granted flit this cycle.
REQ-015 SHALL have port credits, output, [NUM_OUTPORTS][NUM_VCS][$clog2(BUFFER_SIZE+1)], current credit counts.

Function
REQ-016 SHALL keep, per output o, state IDLE or LOCKED(owner input, owner VC), a round-robin pointer rr[o], and one credit counter per (o,vc).
REQ-017 SHALL treat input i as eligible for output o when req[i]=1, req_outport[i]=o, and credits[o][req_vc[i]]>0.
REQ-018 SHALL, in IDLE, grant the eligible input first found scanning from rr[o] upward with wrap-around modulo NUM_INPORTS.
REQ-019 SHALL, in LOCKED, consider only the owner input; all other inputs are ungranted on o regardless of request.
REQ-020 SHALL produce grant, xbar_sel, xbar_valid combinationally in the same cycle as req (zero-cycle allocation); no flit is granted without credit.
REQ-021 SHALL drive xbar_valid[o]=0 and xbar_sel[o]=0 when o grants nobody.
REQ-022 SHALL grant each input at most once per cycle; grant[i]=1 implies xbar_valid[req_outport[i]]=1 and xbar_sel equals i.
REQ-023 SHALL, on an IDLE grant with req_tail=0, transition to LOCKED(i, req_vc[i]) at the next edge.
REQ-024 SHALL, on an IDLE grant with req_tail=1 (single-flit packet), remain IDLE.
REQ-025 SHALL, on a LOCKED grant with req_tail=1, return to IDLE at the next edge.
REQ-026 SHALL update rr[o] to (winner+1) mod NUM_INPORTS only on an IDLE grant; rr is unchanged while LOCKED or when no grant occurs.
REQ-027 SHALL decrement credits[o][v] by 1 on a grant to (o,v) and increment by 1 on credit_return[o][v].
REQ-028 SHALL leave a counter unchanged when grant and credit_return to the same (o,v) coincide.
REQ-029 SHALL saturate a counter at BUFFER_SIZE; a credit_return at BUFFER_SIZE with no grant is ignored.
REQ-030 SHALL, while LOCKED with zero owner-VC credit, stall (no grant, stay LOCKED) until credit returns.
REQ-031 SHALL run outputs independently; different outputs may grant different inputs in the same cycle.

Reset
REQ-032 SHALL, when n_rst=0 at a rising edge, set all outputs to IDLE, rr to 0, and every counter to BUFFER_SIZE, including mid-packet; the partial packet's lock is discarded.
REQ-033 SHALL drive grant=0 and xbar_valid=0 during every cycle n_rst=0, independent of req.

Verification
REQ-034 SHALL cover round-robin: inputs 0,1,2 request out 0, VC0, tail=1, every cycle -> grants 0,1,2,0 on consecutive cycles.
REQ-035 SHALL cover locking: input 1 sends a 3-flit packet to out 1 while input 0 requests out 1 -> grants 1,1,1, then 0; xbar_sel[1]=1 for three cycles.
REQ-036 SHALL cover credit exhaustion: 8 single-flit grants to (0,VC1) with no return -> credits[0][1]=0, 9th request not granted; one credit_return -> granted next cycle.
REQ-037 SHALL cover simultaneous grant and credit_return on (0,0) at credits=5 -> stays 5; return at 8 with no grant -> stays 8.
REQ-038 SHALL cover reset mid-packet: LOCKED on out 0 after flit 2 of 4, n_rst=0 for one cycle -> IDLE, rr=0, all credits=8, grant=0 during reset.
REQ-039 SHALL cover parallel outputs: input 0 -> out 0 and input 2 -> out 1 in the same cycle -> both granted, xbar_sel={2,0}.

Source files
------------

// File: rtl/sw_allocator.sv
// Switch allocator: per-output round-robin arbitration with wormhole packet locking
// and per-(output,VC) credit tracking. Allocation is combinational (zero-cycle).
module sw_allocator #(
  parameter int NUM_INPORTS  = 3,
  parameter int NUM_OUTPORTS = 2,
  parameter int NUM_VCS      = 2,
  parameter int BUFFER_SIZE  = 8,
  localparam int IN_W  = (NUM_INPORTS  > 1) ? $clog2(NUM_INPORTS)  : 1,
  localparam int OP_W  = (NUM_OUTPORTS > 1) ? $clog2(NUM_OUTPORTS) : 1,
  localparam int VC_W  = (NUM_VCS      > 1) ? $clog2(NUM_VCS)      : 1,
  localparam int CNT_W = $clog2(BUFFER_SIZE + 1)
) (
  input  logic                                              clk,
  input  logic                                              n_rst,
  input  logic [NUM_INPORTS-1:0]                            req,
  input  logic [NUM_INPORTS-1:0][OP_W-1:0]                  req_outport,
  input  logic [NUM_INPORTS-1:0][VC_W-1:0]                  req_vc,
  input  logic [NUM_INPORTS-1:0]                            req_tail,
  input  logic [NUM_OUTPORTS-1:0][NUM_VCS-1:0]              credit_return,
  output logic [NUM_INPORTS-1:0]                            grant,
  output logic [NUM_OUTPORTS-1:0][IN_W-1:0]                 xbar_sel,
  output logic [NUM_OUTPORTS-1:0]                           xbar_valid,
  output logic [NUM_OUTPORTS-1:0][NUM_VCS-1:0][CNT_W-1:0]   credits
);

  typedef logic [CNT_W-1:0] cnt_t;
  typedef enum logic {ST_IDLE, ST_LOCKED} state_t;

  localparam cnt_t CNT_MAX = cnt_t'(BUFFER_SIZE);

  // Grant and return on the same cycle cancel; returns beyond full depth are dropped.
  function automatic cnt_t sat_credit(input cnt_t cnt, input logic inc, input logic dec);
    cnt_t res;
    res = cnt;
    if (dec && !inc) begin
      res = cnt - cnt_t'(1);
    end else if (inc && !dec && (cnt < CNT_MAX)) begin
      res = cnt + cnt_t'(1);
    end
    return res;
  endfunction

  state_t                                state_q   [NUM_OUTPORTS];
  state_t                                state_d   [NUM_OUTPORTS];
  logic [NUM_OUTPORTS-1:0][IN_W-1:0]     owner_q, owner_d;
  logic [NUM_OUTPORTS-1:0][VC_W-1:0]     owner_vc_q, owner_vc_d;
  logic [NUM_OUTPORTS-1:0][IN_W-1:0]     rr_q, rr_d;
  cnt_t                                  credit_q  [NUM_OUTPORTS][NUM_VCS];
  cnt_t                                  credit_d  [NUM_OUTPORTS][NUM_VCS];

  logic [NUM_OUTPORTS-1:0][NUM_INPORTS-1:0] elig;
  logic [NUM_OUTPORTS-1:0]                  out_vld;
  logic [NUM_OUTPORTS-1:0][IN_W-1:0]        out_sel;
  logic [NUM_OUTPORTS-1:0][VC_W-1:0]        win_vc;
  logic [NUM_OUTPORTS-1:0]                  win_tail;

  // Allocation: eligibility, per-output arbitration, grant fan-back
  always_comb begin
    int idx;
    elig     = '0;
    out_vld  = '0;
    out_sel  = '0;
    win_vc   = '0;
    win_tail = '0;
    grant    = '0;
    idx      = 0;
    for (int o = 0; o < NUM_OUTPORTS; o++) begin
      for (int i = 0; i < NUM_INPORTS; i++) begin
        elig[o][i] = req[i] && (int'(req_outport[i]) == o) &&
                     (credit_q[o][req_vc[i]] != '0);
      end
      if (state_q[o] == ST_LOCKED) begin
        // A locked output only serves the owner, and only against the owner's VC credit.
        if (req[owner_q[o]] && (int'(req_outport[owner_q[o]]) == o) &&
            (credit_q[o][owner_vc_q[o]] != '0)) begin
          out_vld[o] = 1'b1;
          out_sel[o] = owner_q[o];
        end
      end else begin
        for (int k = 0; k < NUM_INPORTS; k++) begin
          idx = (int'(rr_q[o]) + k) % NUM_INPORTS;
          if (!out_vld[o] && elig[o][idx]) begin
            out_vld[o] = 1'b1;
            out_sel[o] = IN_W'(idx);
          end
        end
      end
      if (!n_rst) begin
        out_vld[o] = 1'b0;
        out_sel[o] = '0;
      end
      if (out_vld[o]) begin
        grant[out_sel[o]] = 1'b1;
        win_tail[o]       = req_tail[out_sel[o]];
        win_vc[o]         = (state_q[o] == ST_LOCKED) ? owner_vc_q[o] : req_vc[out_sel[o]];
      end
    end
  end

  assign xbar_valid = out_vld;
  assign xbar_sel   = out_sel;

  // Next state: lock FSM, round-robin pointer, credit counters
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    owner_vc_d = owner_vc_q;
    rr_d       = rr_q;
    credit_d   = credit_q;
    for (int o = 0; o < NUM_OUTPORTS; o++) begin
      case (state_q[o])
        ST_IDLE: begin
          if (out_vld[o]) begin
            rr_d[o] = IN_W'((int'(out_sel[o]) + 1) % NUM_INPORTS);
            if (!win_tail[o]) begin
              state_d[o]    = ST_LOCKED;
              owner_d[o]    = out_sel[o];
              owner_vc_d[o] = win_vc[o];
            end
          end
        end
        ST_LOCKED: begin
          if (out_vld[o] && win_tail[o]) begin
            state_d[o] = ST_IDLE;
          end
        end
        default: state_d[o] = ST_IDLE;
      endcase
      for (int v = 0; v < NUM_VCS; v++) begin
        credit_d[o][v] = sat_credit(credit_q[o][v], credit_return[o][v],
                                    out_vld[o] && (int'(win_vc[o]) == v));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      owner_q    <= '0;
      owner_vc_q <= '0;
      rr_q       <= '0;
      for (int o = 0; o < NUM_OUTPORTS; o++) begin
        state_q[o] <= ST_IDLE;
        for (int v = 0; v < NUM_VCS; v++) begin
          credit_q[o][v] <= CNT_MAX;
        end
      end
    end else begin
      owner_q    <= owner_d;
      owner_vc_q <= owner_vc_d;
      rr_q       <= rr_d;
      for (int o = 0; o < NUM_OUTPORTS; o++) begin
        state_q[o] <= state_d[o];
        for (int v = 0; v < NUM_VCS; v++) begin
          credit_q[o][v] <= credit_d[o][v];
        end
      end
    end
  end

  always_comb begin
    credits = '0;
    for (int o = 0; o < NUM_OUTPORTS; o++) begin
      for (int v = 0; v < NUM_VCS; v++) begin
        credits[o][v] = credit_q[o][v];
      end
    end
  end

endmodule

// File: tb/tb_sw_allocator.sv
// Directed bench for sw_allocator: arbitration, locking, credits and reset behaviour.
module tb_sw_allocator;

  logic                 clk;
  logic                 n_rst;
  logic [2:0]           req;
  logic [2:0][0:0]      req_outport;
  logic [2:0][0:0]      req_vc;
  logic [2:0]           req_tail;
  logic [1:0][1:0]      credit_return;
  logic [2:0]           grant;
  logic [1:0][1:0]      xbar_sel;
  logic [1:0]           xbar_valid;
  logic [1:0][1:0][3:0] credits;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [15:0] ALL_FULL = {4{4'd8}};

  sw_allocator #(
    .NUM_INPORTS (3),
    .NUM_OUTPORTS(2),
    .NUM_VCS     (2),
    .BUFFER_SIZE (8)
  ) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .req          (req),
    .req_outport  (req_outport),
    .req_vc       (req_vc),
    .req_tail     (req_tail),
    .credit_return(credit_return),
    .grant        (grant),
    .xbar_sel     (xbar_sel),
    .xbar_valid   (xbar_valid),
    .credits      (credits)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_in();
    req           = '0;
    req_outport   = '0;
    req_vc        = '0;
    req_tail      = '0;
    credit_return = '0;
  endtask

  task automatic set_in(input int i, input logic o, input logic v, input logic t);
    req[i]         = 1'b1;
    req_outport[i] = o;
    req_vc[i]      = v;
    req_tail[i]    = t;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    n_rst = 1'b0;
    clear_in();
    step();
    n_rst = 1'b1;
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    clear_in();
    set_in(0, 1'b0, 1'b0, 1'b1);
    set_in(1, 1'b0, 1'b0, 1'b1);
    set_in(2, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    n_checks++;
    if (grant !== 3'b000) begin
      $display("FAIL reset_grant actual=%b required=%b", grant, 3'b000); n_fail++;
    end
    n_checks++;
    if (xbar_valid !== 2'b00 || xbar_sel !== 4'b0000) begin
      $display("FAIL reset_xbar actual valid=%b sel=%b required valid=00 sel=0000",
               xbar_valid, xbar_sel); n_fail++;
    end
    step();
    n_rst = 1'b1;
    clear_in();
    n_checks++;
    if (credits !== ALL_FULL) begin
      $display("FAIL reset_credits actual=%h required=%h", credits, ALL_FULL); n_fail++;
    end
  endtask

  task automatic test_round_robin();
    logic [2:0] exp_g [4];
    logic [1:0] exp_s [4];
    exp_g = '{3'b001, 3'b010, 3'b100, 3'b001};
    exp_s = '{2'd0, 2'd1, 2'd2, 2'd0};
    do_reset();
    set_in(0, 1'b0, 1'b0, 1'b1);
    set_in(1, 1'b0, 1'b0, 1'b1);
    set_in(2, 1'b0, 1'b0, 1'b1);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_checks++;
      if (grant !== exp_g[c] || xbar_sel[0] !== exp_s[c] || xbar_valid !== 2'b01) begin
        $display("FAIL rr_cycle%0d actual grant=%b sel0=%0d valid=%b required grant=%b sel0=%0d valid=01",
                 c, grant, xbar_sel[0], xbar_valid, exp_g[c], exp_s[c]); n_fail++;
      end
      step();
    end
    clear_in();
    n_checks++;
    if (credits[0][0] !== 4'd4) begin
      $display("FAIL rr_credits actual=%0d required=4", credits[0][0]); n_fail++;
    end
  endtask

  task automatic test_locking();
    logic [2:0] exp_g [4];
    logic [1:0] exp_s [4];
    exp_g = '{3'b010, 3'b010, 3'b010, 3'b001};
    exp_s = '{2'd1, 2'd1, 2'd1, 2'd0};
    do_reset();
    set_in(1, 1'b1, 1'b0, 1'b0);
    for (int c = 0; c < 4; c++) begin
      if (c == 1) set_in(0, 1'b1, 1'b1, 1'b1);
      if (c == 2) req_tail[1] = 1'b1;
      if (c == 3) req[1] = 1'b0;
      @(negedge clk);
      n_checks++;
      if (grant !== exp_g[c] || xbar_sel[1] !== exp_s[c] || xbar_valid !== 2'b10) begin
        $display("FAIL lock_cycle%0d actual grant=%b sel1=%0d valid=%b required grant=%b sel1=%0d valid=10",
                 c, grant, xbar_sel[1], xbar_valid, exp_g[c], exp_s[c]); n_fail++;
      end
      step();
    end
    clear_in();
    n_checks++;
    if (credits[1][0] !== 4'd5 || credits[1][1] !== 4'd7) begin
      $display("FAIL lock_credits actual vc0=%0d vc1=%0d required vc0=5 vc1=7",
               credits[1][0], credits[1][1]); n_fail++;
    end
  endtask

  task automatic test_credit_exhaustion();
    do_reset();
    set_in(0, 1'b0, 1'b1, 1'b1);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      n_checks++;
      if (grant !== 3'b001) begin
        $display("FAIL exhaust_grant%0d actual=%b required=001", c, grant); n_fail++;
      end
      step();
    end
    n_checks++;
    if (credits[0][1] !== 4'd0 || credits[0][0] !== 4'd8) begin
      $display("FAIL exhaust_zero actual vc1=%0d vc0=%0d required vc1=0 vc0=8",
               credits[0][1], credits[0][0]); n_fail++;
    end
    credit_return[0][1] = 1'b1;
    @(negedge clk);
    n_checks++;
    if (grant !== 3'b000 || xbar_valid !== 2'b00) begin
      $display("FAIL exhaust_stall actual grant=%b valid=%b required grant=000 valid=00",
               grant, xbar_valid); n_fail++;
    end
    step();
    credit_return = '0;
    n_checks++;
    if (credits[0][1] !== 4'd1) begin
      $display("FAIL exhaust_return actual=%0d required=1", credits[0][1]); n_fail++;
    end
    @(negedge clk);
    n_checks++;
    if (grant !== 3'b001) begin
      $display("FAIL exhaust_regrant actual=%b required=001", grant); n_fail++;
    end
    step();
    clear_in();
    n_checks++;
    if (credits[0][1] !== 4'd0) begin
      $display("FAIL exhaust_final actual=%0d required=0", credits[0][1]); n_fail++;
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    set_in(0, 1'b0, 1'b0, 1'b1);
    repeat (3) step();
    n_checks++;
    if (credits[0][0] !== 4'd5) begin
      $display("FAIL simul_pre actual=%0d required=5", credits[0][0]); n_fail++;
    end
    credit_return[0][0] = 1'b1;
    @(negedge clk);
    n_checks++;
    if (grant !== 3'b001) begin
      $display("FAIL simul_grant actual=%b required=001", grant); n_fail++;
    end
    step();
    n_checks++;
    if (credits[0][0] !== 4'd5) begin
      $display("FAIL simul_hold actual=%0d required=5", credits[0][0]); n_fail++;
    end
    req = '0;
    repeat (3) step();
    n_checks++;
    if (credits[0][0] !== 4'd8) begin
      $display("FAIL simul_refill actual=%0d required=8", credits[0][0]); n_fail++;
    end
    step();
    clear_in();
    n_checks++;
    if (credits[0][0] !== 4'd8) begin
      $display("FAIL simul_saturate actual=%0d required=8", credits[0][0]); n_fail++;
    end
  endtask

  task automatic test_reset_mid_packet();
    do_reset();
    set_in(1, 1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_checks++;
      if (grant !== 3'b010) begin
        $display("FAIL midpkt_flit%0d actual=%b required=010", c, grant); n_fail++;
      end
      step();
    end
    n_checks++;
    if (credits[0][0] !== 4'd6) begin
      $display("FAIL midpkt_credit actual=%0d required=6", credits[0][0]); n_fail++;
    end
    n_rst = 1'b0;
    set_in(2, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    n_checks++;
    if (grant !== 3'b000 || xbar_valid !== 2'b00) begin
      $display("FAIL midpkt_rst_out actual grant=%b valid=%b required grant=000 valid=00",
               grant, xbar_valid); n_fail++;
    end
    step();
    n_rst = 1'b1;
    clear_in();
    n_checks++;
    if (credits !== ALL_FULL) begin
      $display("FAIL midpkt_rst_credits actual=%h required=%h", credits, ALL_FULL); n_fail++;
    end
    // Idle with pointer 0 picks input 0; a kept lock or pointer 2 would not.
    set_in(0, 1'b0, 1'b0, 1'b1);
    set_in(2, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    n_checks++;
    if (grant !== 3'b001 || xbar_sel[0] !== 2'd0) begin
      $display("FAIL midpkt_after actual grant=%b sel0=%0d required grant=001 sel0=0",
               grant, xbar_sel[0]); n_fail++;
    end
    step();
    clear_in();
  endtask

  task automatic test_parallel();
    do_reset();
    set_in(0, 1'b0, 1'b0, 1'b1);
    set_in(2, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    n_checks++;
    if (grant !== 3'b101 || xbar_valid !== 2'b11 || xbar_sel !== 4'b1000) begin
      $display("FAIL parallel actual grant=%b valid=%b sel=%b required grant=101 valid=11 sel=1000",
               grant, xbar_valid, xbar_sel); n_fail++;
    end
    step();
    clear_in();
    n_checks++;
    if (credits[0][0] !== 4'd7 || credits[1][0] !== 4'd7) begin
      $display("FAIL parallel_credits actual o0=%0d o1=%0d required 7 and 7",
               credits[0][0], credits[1][0]); n_fail++;
    end
  endtask

  initial begin
    n_rst = 1'b0;
    clear_in();
    test_reset();
    test_round_robin();
    test_locking();
    test_credit_exhaustion();
    test_simultaneous();
    test_reset_mid_packet();
    test_parallel();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
